// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN    = 32'h8000_0000;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/fa32.sv
// 32-bit adder with carry in and carry out.
module fa32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module mdu_div_step
    import mdu_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic            dvd_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic            q_bit
);

    logic [XLEN-1:0] rem_shift;
    logic [XLEN-1:0] diff;
    logic            no_borrow;

    // rem < 2**k after k steps, so the bit shifted out of rem is always zero.
    assign rem_shift = {rem[XLEN-2:0], dvd_msb};

    fa32 u_sub (
        .a    (rem_shift),
        .b    (~divisor),
        .cin  (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    assign q_bit    = no_borrow;
    assign next_rem = no_borrow ? diff : rem_shift;

endmodule

// File: rtl/mdu_div.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per clock.
module mdu_div #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    import mdu_pkg::*;

    state_t          state, state_nxt;
    op_t             op_sel;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] rem, quo, dvd, dvs;
    logic            neg_q, neg_r, sel_rem;

    logic            signed_op, div_zero, ovf, special, accept, last_step;
    logic [XLEN-1:0] abs_a, abs_b, special_res, fix_q, fix_r;
    logic [XLEN-1:0] step_rem;
    logic            step_q;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

    assign op_sel    = op_t'(op);
    assign signed_op = (op_sel == OP_DIV) || (op_sel == OP_REM);
    assign div_zero  = (b == '0);
    assign ovf       = signed_op && (a == INT_MIN) && (b == '1);
    assign special   = div_zero || ovf;
    assign accept    = (state == IDLE) && start && !kill;
    assign last_step = (cnt == CNT_W'(XLEN - 1));

    // Magnitudes of the operands; INT_MIN maps to itself, which is correct as unsigned.
    assign abs_a = (signed_op && a[XLEN-1]) ? negate(a) : a;
    assign abs_b = (signed_op && b[XLEN-1]) ? negate(b) : b;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = op[1] ? a : DIV_ZERO_Q;
        else if (!op[1])
            special_res = INT_MIN;
    end

    assign fix_q = neg_q ? negate(quo) : quo;
    assign fix_r = neg_r ? negate(rem) : rem;

    mdu_div_step u_step (
        .rem      (rem),
        .dvd_msb  (dvd[XLEN-1]),
        .divisor  (dvs),
        .next_rem (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : CALC;
            CALC: begin
                if (kill)
                    state_nxt = IDLE;
                else if (last_step)
                    state_nxt = FIX;
            end
            FIX:  state_nxt = kill ? IDLE : DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvd     <= '0;
            dvs     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            sel_rem <= 1'b0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && special) begin
                        result <= special_res;
                    end else if (accept) begin
                        dvd     <= abs_a;
                        dvs     <= abs_b;
                        rem     <= '0;
                        quo     <= '0;
                        cnt     <= '0;
                        neg_q   <= signed_op && (a[XLEN-1] ^ b[XLEN-1]);
                        neg_r   <= signed_op && a[XLEN-1];
                        sel_rem <= op[1];
                    end
                end
                CALC: begin
                    if (!kill) begin
                        rem <= step_rem;
                        quo <= {quo[XLEN-2:0], step_q};
                        dvd <= {dvd[XLEN-2:0], 1'b0};
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (!kill)
                        result <= sel_rem ? fix_r : fix_q;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mdu_div.sv
// Self-checking bench for mdu_div: directed corner cases plus random operations vs. an arithmetic model.
module tb_mdu_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        kill = 1'b0;
    logic        busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;

    mdu_div dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RISC-V M semantics straight from the ISA rules, using 64-bit host arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        if (o[0]) begin
            if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
            return o[1] ? (x % y) : (x / y);
        end
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (sy == 0) begin
            q = -1;
            r = sx;
        end else begin
            q = sx / sy;
            r = sx % sy;
        end
        return o[1] ? 32'(r) : 32'(q);
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 0) return 1;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issue one operation; optionally poke a start with a=1,b=1 while busy at cycle 'poke'.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int poke, input bit full);
        logic [31:0] exp_r;
        int          cyc;
        bit          busy_ok;
        exp_r = ref_div(o, x, y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 100) begin
            if (!busy) busy_ok = 1'b0;
            start = (cyc == poke);
            if (cyc == poke) begin
                a = 32'd1;
                b = 32'd1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, " result"}, result, exp_r);
        check({tag, " latency"}, 32'(cyc), 32'(ref_lat(o, x, y)));
        if (full) begin
            check({tag, " done"}, {31'd0, done}, 32'd1);
            check({tag, " busy_during"}, {31'd0, busy_ok & busy}, 32'd1);
            @(negedge clk);
            check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
            check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int d0;
        logic [31:0] x, y;
        logic [1:0]  o;

        #2;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("divu 20/3", 2'b01, 32'd20, 32'd3, 0, 1'b1);
        run_op("remu 20/3", 2'b11, 32'd20, 32'd3, 0, 1'b1);
        run_op("div -20/3", 2'b00, 32'hFFFF_FFEC, 32'd3, 0, 1'b1);
        run_op("rem -20/3", 2'b10, 32'hFFFF_FFEC, 32'd3, 0, 1'b1);
        run_op("rem 20/-3", 2'b10, 32'd20, 32'hFFFF_FFFD, 0, 1'b1);
        run_op("divu max/2", 2'b01, 32'hFFFF_FFFF, 32'd2, 0, 1'b1);
        run_op("remu max/2", 2'b11, 32'hFFFF_FFFF, 32'd2, 0, 1'b1);
        run_op("div 7/0", 2'b00, 32'd7, 32'd0, 0, 1'b1);
        run_op("rem 7/0", 2'b10, 32'd7, 32'd0, 0, 1'b1);
        run_op("divu 7/0", 2'b01, 32'd7, 32'd0, 0, 1'b1);
        run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
        run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
        run_op("divu intmin/-1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
        run_op("divu 100/7 poke", 2'b01, 32'd100, 32'd7, 5, 1'b1);

        // Kill part-way through CALC: no done, result held.
        d0 = done_seen;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("kill busy_before", {31'd0, busy}, 32'd1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill busy_after", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("kill no_done", 32'(done_seen - d0), 32'd0);
        check("kill result_held", result, 32'd14);

        // Kill in IDLE blocks start for that cycle only.
        @(negedge clk);
        start = 1'b1; kill = 1'b1; op = 2'b01; a = 32'd50; b = 32'd7;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("idle kill no_accept", {31'd0, busy}, 32'd0);
        run_op("divu 9/2 after kill", 2'b01, 32'd9, 32'd2, 0, 1'b1);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd12345; b = 32'd17;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("async rst busy", {31'd0, busy}, 32'd0);
        check("async rst done", {31'd0, done}, 32'd0);
        check("async rst result", result, 32'd0);
        #3 rst = 1'b0;
        d0 = done_seen;
        repeat (40) @(negedge clk);
        check("rst no_done", 32'(done_seen - d0), 32'd0);

        // Random operations with operands biased toward the corners.
        for (int i = 0; i < 200; i++) begin
            o = 2'($urandom);
            case ($urandom_range(0, 5))
                0: x = 32'h8000_0000;
                1: x = $urandom_range(0, 40);
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: y = $urandom_range(1, 9);
                3: y = $urandom >> $urandom_range(0, 31);
                default: y = $urandom;
            endcase
            run_op($sformatf("rand%0d op%0d", i, o), o, x, y, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
